timer_alarm_sched: RTL and testbench
====================================

Name: timer_alarm_sched

Overview:
- Shares one 15-bit free-running real-time timer (1.28 us tick, 781250 Hz, wraps 32767 -> 0) among NUM_CH requesters as one-shot alarms.
- Requesters arm a delay through a round-robin req/ack handshake.
- A single shared comparator scans the channels one per clock and pulses `expire` when a channel's delay has elapsed.
- Sits beside the real-time timer in the system clock domain. It is the only consumer that converts timer values into per-client timeout events.

Parameters:
- NUM_CH, 4: number of alarm channels. Legal range 1..32 and must not exceed system clocks per timer tick (64 at 50 MHz).
- TW, 15: timer width in bits. Fixed to 15 and held in the package.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- timer_in  in  16  real-time timer value; bit 15 is ignored (always 0).
- arm_req  in  NUM_CH  per-channel arm request; held until `arm_ack`.
- arm_delay  in  NUM_CH*15  per-channel delay in ticks; channel i occupies bits [15*i+14:15*i]; must be stable while `arm_req` is high.
- arm_ack  out  NUM_CH  registered one-cycle pulse; at most one bit set.
- cancel  in  NUM_CH  level; disarms the channel.
- active  out  NUM_CH  channel armed and not yet expired.
- expire  out  NUM_CH  registered one-cycle pulse on expiry; at most one bit set.

Behaviour:
- Reset (async assert): `arm_ack`, `active` and `expire` all 0; stored start/delay values 0; round-robin pointer 0; scan_ptr 0. Pending alarms are discarded with no `expire`. Outputs are reset-valued for as long as reset is held.
- Arbitration, one grant per cycle:
  - Eligible = `arm_req` & ~`arm_ack` & ~`cancel`.
  - Search order starts at the round-robin pointer; after a grant to channel g, pointer <= (g+1) mod NUM_CH.
  - Grant in cycle t: start[g] <= timer_in[14:0], dly[g] <= arm_delay slice g, active[g] <= 1, arm_ack[g] <= 1 (visible in cycle t+1).
  - Requester drops `arm_req` in the cycle it sees `arm_ack`.
- Re-arm while active: allowed; start and dly are overwritten, so the timer restarts. No `expire` is produced for the old alarm.
- Scanner:
  - scan_ptr increments every clock and wraps NUM_CH-1 -> 0.
  - For channel c = scan_ptr with active[c]=1: elapsed = (timer_in[14:0] - start[c]) mod 2^15.
  - If elapsed >= dly[c]: active[c] <= 0 and expire[c] <= 1 for exactly one cycle.
- Latency: `expire` asserts 1..NUM_CH+1 clocks after timer_in first reaches start+dly.
- Delay 0: the channel expires on its first scan visit after the grant.
- Delay 32767: the maximum. Wrap-around is handled by the modular subtraction; no alarm is lost across timer wrap, because every channel is visited once per NUM_CH clocks, which is less than one tick.
- Same-cycle priority on one channel: cancel > arm grant > expiry check.
  - Cancel clears `active` and suppresses both the grant and the expiry.
  - A grant coinciding with a scan hit suppresses `expire` and restarts the alarm.
- Timer reset without scheduler reset: elapsed is computed modularly and may fire late by up to 32768 ticks. The timer and the scheduler are reset together at system level.

Optional Feature:
- Macro: TIMER_ALARM_SCHED_PERIODIC_EN.
- With the macro:
  - Extra input port `periodic` (NUM_CH bits) is sampled at grant into a per-channel mode bit.
  - On expiry, a periodic channel pulses `expire`, keeps active=1, and sets start <= (start + dly) mod 2^15, giving a drift-free period.
  - A periodic channel with dly=0 behaves as one-shot.
  - Cancel stops it.
- Without the macro: no `periodic` port; all channels are one-shot.

Decomposition:
- Package timer_sched_pkg holds:
  - TW = 15.
  - typedef tick_t (15-bit).
  - Function elapsed(now, start), returning a tick_t.
  - MAX_CH = 32.
- Sub-module rr_arbiter: NUM_CH requests in, one-hot grant out, pointer register inside. It is reused for other shared resources.

Test Plan:
- Reset, then arm ch0 with delay 10 at timer=100 -> `arm_ack`[0] one cycle later. `expire`[0] is a single pulse within NUM_CH+1 clocks of timer=110; `active`[0] falls with it.
- Arm ch1 with delay 20 at timer=32760 -> `expire`[1] fires after timer wraps to 12 (not at 32760 + 20 unwrapped); no spurious expiry before the wrap.
- `arm_req`=4'b1111 held continuously, delays 5/6/7/8 -> acks granted ch0, ch1, ch2, ch3 on consecutive cycles; one-hot check; four distinct expires.
- Arm ch2 with delay 50, assert `cancel`[2] at timer=start+10 -> `active`[2]=0 next cycle; no `expire`[2] ever.
  - Repeat with `cancel` asserted in the same cycle as `arm_req` -> no `arm_ack`.
- Arm ch3 with delay 100, re-arm at +60 with delay 100 -> single `expire` at original+160. Separately, delay 0 -> `expire` within NUM_CH+1 clocks.
- Assert reset with 3 channels armed -> all outputs 0 immediately; no expire after release. With the PERIODIC_EN macro: periodic ch0 with delay 4 -> expire every 4 ticks for 10 periods with no drift.

Source files
------------

// File: rtl/timer_sched_pkg.sv
// Shared types and helpers for the alarm scheduler: timer width, tick type
// and the modular elapsed-time function.
package timer_sched_pkg;

  localparam int unsigned TW     = 15;
  localparam int unsigned MAX_CH = 32;

  typedef logic [TW-1:0] tick_t;

  // Unsigned subtraction in TW bits is the wrap-safe distance from start to now.
  function automatic tick_t elapsed(input tick_t now, input tick_t start);
    return now - start;
  endfunction

endpackage

// File: rtl/timer_alarm_sched_rr_arbiter.sv
// Generic round-robin arbiter: N requests in, one-hot grant out. The search
// starts at the pointer, which moves just past each granted requester.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] pos;
  int unsigned   idx;
  logic          found;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    pos   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      pos = PW'(idx);
      if (!found && req_i[pos]) begin
        gnt_o[pos] = 1'b1;
        found      = 1'b1;
        ptr_d      = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/timer_alarm_sched.sv
// One-shot alarm scheduler sharing a 15-bit real-time timer among NUM_CH
// channels. Optional periodic mode: define TIMER_ALARM_SCHED_PERIODIC_EN.
module timer_alarm_sched
  import timer_sched_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [15:0]          timer_in,
  input  logic [NUM_CH-1:0]    arm_req,
  input  logic [NUM_CH*TW-1:0] arm_delay,
  output logic [NUM_CH-1:0]    arm_ack,
  input  logic [NUM_CH-1:0]    cancel,
`ifdef TIMER_ALARM_SCHED_PERIODIC_EN
  input  logic [NUM_CH-1:0]    periodic,
`endif
  output logic [NUM_CH-1:0]    active,
  output logic [NUM_CH-1:0]    expire
);

  localparam int unsigned PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  tick_t now;
  logic  unused_timer_msb;

  tick_t start_q [NUM_CH];
  tick_t start_d [NUM_CH];
  tick_t dly_q   [NUM_CH];
  tick_t dly_d   [NUM_CH];

  logic [NUM_CH-1:0] active_q, active_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic [NUM_CH-1:0] exp_q, exp_d;
  logic [NUM_CH-1:0] per_q, per_d;
  logic [NUM_CH-1:0] per_sel;
  logic [NUM_CH-1:0] eligible, grant;
  logic [PW-1:0]     scan_q, scan_d;

  tick_t sel_start, sel_dly;
  logic  sel_act, scan_hit;

  assign now              = timer_in[TW-1:0];
  assign unused_timer_msb = timer_in[15];

`ifdef TIMER_ALARM_SCHED_PERIODIC_EN
  assign per_sel = periodic;
`else
  assign per_sel = '0;
`endif

  assign eligible = arm_req & ~ack_q & ~cancel;

  rr_arbiter #(
    .N(NUM_CH)
  ) u_arb (
    .clk_i (clock),
    .rst_i (reset),
    .req_i (eligible),
    .gnt_o (grant)
  );

  assign scan_d = (scan_q == PW'(NUM_CH - 1)) ? '0 : scan_q + 1'b1;

  // Mux the scanned channel onto one comparator rather than one per channel.
  always_comb begin
    sel_start = '0;
    sel_dly   = '0;
    sel_act   = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (scan_q == PW'(i)) begin
        sel_start = start_q[i];
        sel_dly   = dly_q[i];
        sel_act   = active_q[i];
      end
    end
    scan_hit = sel_act && (elapsed(now, sel_start) >= sel_dly);
  end

  // Per-channel priority: cancel, then grant, then expiry.
  always_comb begin
    start_d  = start_q;
    dly_d    = dly_q;
    active_d = active_q;
    per_d    = per_q;
    ack_d    = '0;
    exp_d    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cancel[i]) begin
        active_d[i] = 1'b0;
      end else if (grant[i]) begin
        start_d[i]  = now;
        dly_d[i]    = arm_delay[TW*i +: TW];
        active_d[i] = 1'b1;
        ack_d[i]    = 1'b1;
        per_d[i]    = per_sel[i];
      end else if (scan_hit && (scan_q == PW'(i))) begin
        exp_d[i] = 1'b1;
        if (per_q[i] && (dly_q[i] != '0)) start_d[i] = start_q[i] + dly_q[i];
        else                              active_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        start_q[i] <= '0;
        dly_q[i]   <= '0;
      end
      active_q <= '0;
      ack_q    <= '0;
      exp_q    <= '0;
      per_q    <= '0;
      scan_q   <= '0;
    end else begin
      start_q  <= start_d;
      dly_q    <= dly_d;
      active_q <= active_d;
      ack_q    <= ack_d;
      exp_q    <= exp_d;
      per_q    <= per_d;
      scan_q   <= scan_d;
    end
  end

  assign arm_ack = ack_q;
  assign active  = active_q;
  assign expire  = exp_q;

endmodule

// File: tb/tb_timer_alarm_sched.sv
// Bench for timer_alarm_sched: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a behavioural alarm model.
module tb_timer_alarm_sched;

  localparam int unsigned N   = 4;
  localparam int unsigned TPC = 8;  // system clocks per timer tick

  logic          clock = 1'b0;
  logic          reset;
  logic [15:0]   timer_in;
  logic [N-1:0]  arm_req, cancel, periodic_v;
  logic [N-1:0]  arm_ack, active, expire;
  logic [N*15-1:0] arm_delay;

  always #5 clock = ~clock;

  timer_alarm_sched #(.NUM_CH(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .timer_in  (timer_in),
    .arm_req   (arm_req),
    .arm_delay (arm_delay),
    .arm_ack   (arm_ack),
    .cancel    (cancel),
`ifdef TIMER_ALARM_SCHED_PERIODIC_EN
    .periodic  (periodic_v),
`endif
    .active    (active),
    .expire    (expire)
  );

  // Reference model: alarm records, round-robin pointer and scan position.
  int unsigned m_start [N];
  int unsigned m_dly   [N];
  bit [N-1:0]  m_act, m_ack, m_exp, m_per;
  int unsigned m_rr, m_scan;

  int unsigned timer_v, tick_cnt;
  bit          msb_noise;
  int unsigned exp_cnt  [N];
  int unsigned exp_time [N];
  int          checks, failures;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_start[i] = 0;
      m_dly[i]   = 0;
    end
    m_act = '0; m_ack = '0; m_exp = '0; m_per = '0;
    m_rr = 0; m_scan = 0;
  endtask

  task automatic model_edge();
    bit [N-1:0]  elig, gnt, n_ack, n_exp;
    int unsigned now, c, el;
    if (reset) begin
      model_clear();
      return;
    end
    elig = arm_req & ~m_ack & ~cancel;
    gnt  = '0;
    for (int k = 0; k < N; k++) begin
      c = (m_rr + k) % N;
      if (elig[c] && gnt == '0) begin
        gnt[c] = 1'b1;
        m_rr   = (c + 1) % N;
      end
    end
    now   = timer_v % 32768;
    n_ack = '0;
    n_exp = '0;
    for (int i = 0; i < N; i++) begin
      el = (now + 32768 - m_start[i]) % 32768;
      if (cancel[i]) begin
        m_act[i] = 1'b0;
      end else if (gnt[i]) begin
        m_start[i] = now;
        m_dly[i]   = arm_delay[15*i +: 15];
        m_act[i]   = 1'b1;
        m_per[i]   = periodic_v[i];
        n_ack[i]   = 1'b1;
      end else if (i == m_scan && m_act[i] && el >= m_dly[i]) begin
        n_exp[i] = 1'b1;
        if (m_per[i] && m_dly[i] != 0) m_start[i] = (m_start[i] + m_dly[i]) % 32768;
        else                           m_act[i] = 1'b0;
      end
    end
    m_ack  = n_ack;
    m_exp  = n_exp;
    m_scan = (m_scan + 1) % N;
  endtask

  task automatic drive_timer();
    timer_in = {msb_noise ? 1'($urandom) : 1'b0, timer_v[14:0]};
  endtask

  task automatic set_timer(input int unsigned v);
    timer_v  = v % 32768;
    tick_cnt = 0;
    drive_timer();
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check("arm_ack", arm_ack, m_ack);
    check("active", active, m_act);
    check("expire", expire, m_exp);
    check("one_hot", ($countones(arm_ack) <= 1) && ($countones(expire) <= 1), 1);
    for (int i = 0; i < N; i++) begin
      if (expire[i] === 1'b1) begin
        exp_cnt[i]++;
        exp_time[i] = timer_v;
      end
    end
    tick_cnt++;
    if (tick_cnt == TPC) begin
      tick_cnt = 0;
      timer_v  = (timer_v + 1) % 32768;
    end
    drive_timer();
  endtask

  task automatic wait_ticks(input int unsigned n);
    repeat (n * TPC) step();
  endtask

  task automatic wait_timer(input int unsigned v, input int unsigned budget_ticks);
    int unsigned n = 0;
    while (timer_v != v && n < budget_ticks * TPC) begin
      step();
      n++;
    end
    if (timer_v != v) check("wait_timer", timer_v, v);
  endtask

  task automatic arm(input int ch, input int unsigned dly);
    arm_delay[15*ch +: 15] = 15'(dly);
    arm_req[ch] = 1'b1;
    for (int k = 0; k < 4 * N && !m_ack[ch]; k++) step();
    arm_req[ch] = 1'b0;
    check("arm_grant", arm_ack[ch], 1);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) begin
      exp_cnt[i]  = 0;
      exp_time[i] = 0;
    end
  endtask

  // Asserts reset between edges and checks that outputs clear at once.
  task automatic do_reset();
    #2 reset = 1'b1;
    arm_req = '0;
    cancel  = '0;
    #1;
    check("rst_ack", arm_ack, 0);
    check("rst_active", active, 0);
    check("rst_expire", expire, 0);
    model_clear();
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; arm_req = '0; cancel = '0; periodic_v = '0; arm_delay = '0;
    msb_noise = 1'b0;
    set_timer(0);
    model_clear();
    clear_counts();
    @(negedge clock);
    do_reset();

    // Basic one-shot
    set_timer(100); clear_counts();
    arm(0, 10);
    wait_timer(110, 20);
    repeat (N + 1) step();
    check("s1_exp_cnt", exp_cnt[0], 1);
    check("s1_exp_time", exp_time[0], 110);
    check("s1_active", active[0], 0);

    // Expiry across timer wrap
    do_reset(); set_timer(32760); clear_counts();
    arm(1, 20);
    wait_ticks(10);
    check("s2_no_early", exp_cnt[1], 0);
    wait_timer(12, 40);
    repeat (N + 1) step();
    check("s2_exp_cnt", exp_cnt[1], 1);
    check("s2_exp_time", exp_time[1], 12);

    // Round-robin grants on consecutive cycles
    do_reset(); clear_counts();
    for (int i = 0; i < N; i++) arm_delay[15*i +: 15] = 15'(5 + i);
    arm_req = '1;
    for (int k = 0; k < N; k++) begin
      step();
      check("rr_ack", arm_ack, 1 << k);
      arm_req[k] = 1'b0;
    end
    wait_ticks(12);
    for (int i = 0; i < N; i++) check("rr_exp_cnt", exp_cnt[i], 1);

    // Cancel while active, then cancel colliding with a request
    do_reset(); clear_counts();
    arm(2, 50);
    wait_ticks(10);
    cancel[2] = 1'b1;
    step();
    cancel[2] = 1'b0;
    check("cancel_active", active[2], 0);
    wait_ticks(50);
    check("cancel_no_exp", exp_cnt[2], 0);
    arm_delay[30 +: 15] = 15'd5;
    arm_req[2] = 1'b1; cancel[2] = 1'b1;
    step();
    check("cancel_no_ack", arm_ack[2], 0);
    arm_req[2] = 1'b0; cancel[2] = 1'b0;
    step();
    check("cancel_no_ack2", arm_ack[2], 0);

    // Re-arm restarts the alarm; delay 0 fires on first visit
    do_reset(); set_timer(1000); clear_counts();
    arm(3, 100);
    wait_timer(1060, 80);
    arm(3, 100);
    wait_timer(1159, 120);
    check("rearm_no_old", exp_cnt[3], 0);
    wait_timer(1160, 4);
    repeat (N + 1) step();
    check("rearm_cnt", exp_cnt[3], 1);
    check("rearm_time", exp_time[3], 1160);
    arm(0, 0);
    repeat (N + 1) step();
    check("dly0_cnt", exp_cnt[0], 1);

    // Reset discards pending alarms
    do_reset(); clear_counts();
    arm(0, 30); arm(1, 40); arm(2, 50);
    check("pre_rst_active", active, 4'b0111);
    do_reset();
    wait_ticks(60);
    check("post_rst_exp", exp_cnt[0] + exp_cnt[1] + exp_cnt[2] + exp_cnt[3], 0);

`ifdef TIMER_ALARM_SCHED_PERIODIC_EN
    do_reset(); set_timer(200); clear_counts();
    periodic_v[0] = 1'b1;
    arm(0, 4);
    periodic_v = '0;
    for (int p = 1; p <= 10; p++) begin
      wait_timer(200 + 4 * p, 8);
      repeat (N + 1) step();
      check("per_cnt", exp_cnt[0], p);
      check("per_time", exp_time[0], 200 + 4 * p);
    end
    cancel[0] = 1'b1;
    step();
    cancel[0] = 1'b0;
    wait_ticks(10);
    check("per_cancel", exp_cnt[0], 10);
`endif

    // Randomized traffic across a timer wrap, with noise on timer bit 15
    do_reset(); set_timer(32700); clear_counts();
    msb_noise = 1'b1;
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if (arm_req[i] && m_ack[i]) begin
          arm_req[i] = 1'b0;
        end else if (!arm_req[i] && $urandom_range(0, 15) == 0) begin
          arm_delay[15*i +: 15] = ($urandom_range(0, 15) == 0) ? 15'h7fff : 15'($urandom_range(0, 30));
`ifdef TIMER_ALARM_SCHED_PERIODIC_EN
          periodic_v[i] = 1'($urandom);
`endif
          arm_req[i] = 1'b1;
        end
        cancel[i] = ($urandom_range(0, 63) == 0);
      end
      step();
    end
    arm_req = '0; cancel = '1; msb_noise = 1'b0;
    step();
    cancel = '0;
    repeat (2 * N) step();
    check("drain_idle", active, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
